// File: rtl/signal_pulse_stretcher_pkg.sv
// Shared types and helpers for the pulse stretcher: state encoding and
// a compile-time max used to size the shared phase counter.
package signal_pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_GAP    = 2'd2
  } state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/signal_pulse_stretcher_edge_detector.sv
// Single-cycle pulse on the inactive-to-active transition of a
// sys_clk-synchronous level; polarity normalised by IN_ACTIVE_LOW.
module signal_edge_detector #(
  parameter bit IN_ACTIVE_LOW = 1'b0
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic sig,
  output logic pulse
);

  logic level;
  logic prev;

  assign level = sig ^ IN_ACTIVE_LOW;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) prev <= 1'b0;
    else        prev <= level;
  end

  assign pulse = level & ~prev;

endmodule

// File: rtl/signal_pulse_stretcher.sv
// Stretches request edges into fixed-width pulses with a guaranteed
// inactive gap, queuing up to MAX_PENDING requests that arrive meanwhile.
module signal_pulse_stretcher
  import signal_pulse_stretcher_pkg::*;
#(
  parameter int unsigned ACTIVE_COUNT   = 65536,
  parameter int unsigned GAP_COUNT      = 65536,
  parameter int unsigned MAX_PENDING    = 3,
  parameter bit          IN_ACTIVE_LOW  = 1'b0,
  parameter bit          OUT_ACTIVE_LOW = 1'b1
) (
  input  logic                               sys_clk,
  input  logic                               rst_n,
  input  logic                               in_sig,
  output logic                               out_sig,
  output logic                               busy,
  output logic [$clog2(MAX_PENDING+1)-1:0]   pending_cnt,
  output logic                               overflow
);

  localparam int unsigned CNT_MAX = max_u(ACTIVE_COUNT, GAP_COUNT);
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned PEND_W  = $clog2(MAX_PENDING + 1);

  localparam logic [CNT_W-1:0]  ACT_LAST = CNT_W'(ACTIVE_COUNT - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST = CNT_W'(GAP_COUNT - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PEND_W-1:0]  pend_d;
  logic               ovf_d;
  logic               req;
  logic               last_gap;

  signal_edge_detector #(
    .IN_ACTIVE_LOW(IN_ACTIVE_LOW)
  ) u_edge (
    .sys_clk(sys_clk),
    .rst_n  (rst_n),
    .sig    (in_sig),
    .pulse  (req)
  );

  assign last_gap = (state_q == ST_GAP) && (cnt_q == GAP_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    pend_d  = pending_cnt;
    ovf_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (req) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (cnt_q == ACT_LAST) begin
          state_d = ST_GAP;
          cnt_d   = '0;
        end
      end
      ST_GAP: begin
        if (last_gap) begin
          cnt_d = '0;
          // A request on this edge is served directly, so a full queue
          // nets to no change and never overflows.
          if (req || (pending_cnt != '0)) begin
            state_d = ST_ACTIVE;
            if (!req) pend_d = pending_cnt - 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (req && (state_q != ST_IDLE) && !last_gap) begin
      if (pending_cnt != PEND_MAX) pend_d = pending_cnt + 1'b1;
      else                         ovf_d  = 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      pending_cnt <= '0;
      overflow    <= 1'b0;
      busy        <= 1'b0;
      out_sig     <= OUT_ACTIVE_LOW;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pending_cnt <= pend_d;
      overflow    <= ovf_d;
      busy        <= (state_d != ST_IDLE);
      out_sig     <= (state_d == ST_ACTIVE) ^ OUT_ACTIVE_LOW;
    end
  end

endmodule

// File: tb/tb_signal_pulse_stretcher.sv
// Bench for signal_pulse_stretcher: window-based reference model compared
// every cycle, directed scenarios with literal pulse statistics, then random traffic.
module tb_signal_pulse_stretcher;

  localparam int A  = 4;
  localparam int G  = 3;
  localparam int MP = 2;

  logic       sys_clk = 1'b0;
  logic       rst_n   = 1'b0;
  logic       in_sig  = 1'b0;
  logic       out_sig;
  logic       busy;
  logic [1:0] pending_cnt;
  logic       overflow;

  signal_pulse_stretcher #(
    .ACTIVE_COUNT  (A),
    .GAP_COUNT     (G),
    .MAX_PENDING   (MP),
    .IN_ACTIVE_LOW (1'b0),
    .OUT_ACTIVE_LOW(1'b1)
  ) dut (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .in_sig     (in_sig),
    .out_sig    (out_sig),
    .busy       (busy),
    .pending_cnt(pending_cnt),
    .overflow   (overflow)
  );

  always #5 sys_clk = ~sys_clk;

  int checks   = 0;
  int failures = 0;

  // Model: rem = cycles left in the current pulse+gap window (0 = idle).
  int rem   = 0;
  int mpend = 0;
  bit mprev = 1'b0;
  bit movf  = 1'b0;

  // Statistics over model outputs, cleared per scenario.
  int s_act, s_pulses, s_busy, s_ovf, s_maxp;
  bit s_prev_act;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  initial begin : model
    bit r;
    int p;
    forever begin
      @(posedge sys_clk or negedge rst_n);
      if (!rst_n) begin
        rem = 0; mpend = 0; mprev = 1'b0; movf = 1'b0;
      end else begin
        r     = in_sig && !mprev;
        mprev = in_sig;
        movf  = 1'b0;
        if (rem == 0) begin
          if (r) rem = A + G;
        end else if (rem == 1) begin
          p = mpend + (r ? 1 : 0);
          if (p > 0) begin
            rem   = A + G;
            mpend = p - 1;
          end else begin
            rem = 0;
          end
        end else begin
          rem--;
          if (r) begin
            if (mpend < MP) mpend++;
            else            movf = 1'b1;
          end
        end
      end
    end
  end

  initial begin : compare
    bit ma;
    forever begin
      @(negedge sys_clk);
      ma = (rem > G);
      check("out_sig",     int'(out_sig),     ma ? 0 : 1);
      check("busy",        int'(busy),        (rem > 0) ? 1 : 0);
      check("pending_cnt", int'(pending_cnt), mpend);
      check("overflow",    int'(overflow),    int'(movf));
      if (ma) s_act++;
      if (ma && !s_prev_act) s_pulses++;
      s_prev_act = ma;
      if (rem > 0) s_busy++;
      if (movf) s_ovf++;
      if (mpend > s_maxp) s_maxp = mpend;
    end
  end

  task automatic step();
    @(negedge sys_clk);
    #1;
  endtask

  task automatic clear_stats();
    s_act = 0; s_pulses = 0; s_busy = 0; s_ovf = 0; s_maxp = 0; s_prev_act = 1'b0;
  endtask

  task automatic scen(input string nm, input logic [63:0] pat, input int len,
                      input int act_e, input int pulses_e, input int busy_e,
                      input int ovf_e, input int maxp_e);
    clear_stats();
    for (int i = 0; i < len; i++) begin
      in_sig = pat[i];
      step();
    end
    in_sig = 1'b0;
    repeat (30) step();
    check({nm, "_active_cycles"}, s_act,    act_e);
    check({nm, "_pulses"},        s_pulses, pulses_e);
    check({nm, "_busy_cycles"},   s_busy,   busy_e);
    check({nm, "_overflows"},     s_ovf,    ovf_e);
    check({nm, "_max_pending"},   s_maxp,   maxp_e);
  endtask

  initial begin : stim
    clear_stats();
    rst_n  = 1'b0;
    in_sig = 1'b0;
    repeat (3) step();
    check("rst_out_sig",  int'(out_sig),     1);
    check("rst_busy",     int'(busy),        0);
    check("rst_pending",  int'(pending_cnt), 0);
    check("rst_overflow", int'(overflow),    0);
    rst_n = 1'b1;
    repeat (5) step();

    scen("single",     64'h1,     1,  4, 1,  7, 0, 0);
    scen("held",       64'hFFFFF, 20, 4, 1,  7, 0, 0);
    scen("three",      64'h15,    5, 12, 3, 21, 0, 2);
    scen("four",       64'h55,    7, 12, 3, 21, 1, 2);
    scen("lastgap",    64'h95,    8, 16, 4, 28, 0, 2);

    // Asynchronous reset in the middle of a pulse with one request queued.
    in_sig = 1'b1; step();
    in_sig = 1'b0; step();
    in_sig = 1'b1; step();
    in_sig = 1'b0;
    check("pre_rst_pending", int'(pending_cnt), 1);
    @(posedge sys_clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_out_sig", int'(out_sig),     1);
    check("async_busy",    int'(busy),        0);
    check("async_pending", int'(pending_cnt), 0);
    repeat (2) step();
    rst_n = 1'b1;
    clear_stats();
    repeat (25) step();
    check("post_rst_pulses", s_pulses, 0);
    check("post_rst_busy",   s_busy,   0);

    for (int i = 0; i < 4000; i++) begin
      in_sig = ($urandom_range(0, 99) < 30);
      if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
      step();
      rst_n = 1'b1;
    end
    in_sig = 1'b0;
    repeat (30) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
